// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and constants for the ALU command path: opcode
//            type, command record and issue-FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Default widths; the issue block and FIFO default their parameters to these
    localparam int c_DATA_W = 8;
    localparam int c_OP_W   = 4;
    localparam int c_TAG_W  = 4;

    typedef logic [c_OP_W-1:0] alu_op_t;

    // Opcode encodings understood by the downstream ALU
    localparam alu_op_t c_OP_ADD = 4'h0;
    localparam alu_op_t c_OP_SUB = 4'h1;
    localparam alu_op_t c_OP_AND = 4'h2;
    localparam alu_op_t c_OP_OR  = 4'h3;
    localparam alu_op_t c_OP_XOR = 4'h4;
    localparam alu_op_t c_OP_SHL = 4'h5;
    localparam alu_op_t c_OP_SHR = 4'h6;
    localparam alu_op_t c_OP_CMP = 4'h7;

    typedef struct packed {
        alu_op_t             op;
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module   : alu_cmd_fifo
// Brief    : Synchronous FIFO of ALU commands with occupancy count and a
//            synchronous clear that overrides push and pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type ENTRY_T = alu_cmd_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  ENTRY_T           wr_data,
    output ENTRY_T           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    ENTRY_T           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard against overflow/underflow; clear suppresses both sides
    always_comb begin
        w_do_push = push && !full && !clear;
        w_do_pop  = pop && !empty && !clear;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // Head entry and status flags
    always_comb begin
        rd_data = r_mem[r_rd_ptr];
        count   = r_count;
        full    = (r_count == CNT_W'(DEPTH));
        empty   = (r_count == '0);
    end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_issue.sv
// ============================================================================
// Module   : alu_cmd_issue
// Brief    : Buffers ALU commands from a valid/ready source and issues one
//            per cycle to the ALU with a registered strobe, sequence tag,
//            stall back-pressure and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int  DATA_W = c_DATA_W,
    parameter int  OP_W   = c_OP_W,
    parameter int  DEPTH  = 8,
    parameter int  TAG_W  = c_TAG_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              flush,
    input  logic              alu_stall,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [TAG_W-1:0]  alu_tag,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       issued_cnt
);

    issue_state_e     r_state;
    issue_state_e     w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count_nxt;
    alu_cmd_t         w_push_cmd;
    alu_cmd_t         w_head;
    logic [TAG_W-1:0] r_tag_ctr;

    // Pack the incoming command fields into the FIFO record
    always_comb begin
        w_push_cmd.op = alu_op_t'(in_op);
        w_push_cmd.a  = c_DATA_W'(in_a);
        w_push_cmd.b  = c_DATA_W'(in_b);
    end

    alu_cmd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (alu_cmd_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_push_cmd),
        .rd_data (w_head),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; IDLE looks at the post-edge count so a push into an empty
    // FIFO is issued on the very next edge
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                IDLE:    if (w_count_nxt != '0) w_state_nxt = RUN;
                RUN: begin
                    if (w_count_nxt == '0) w_state_nxt = IDLE;
                    else if (alu_stall)    w_state_nxt = STALL;
                end
                STALL:   if (!alu_stall) w_state_nxt = RUN;
                FLUSH:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: handshake, issue decision and projected occupancy
    always_comb begin
        in_ready    = rst_n && !w_full && (r_state != FLUSH);
        w_push      = in_valid && in_ready && !flush;
        w_pop       = (r_state == RUN) && !w_empty && !alu_stall && !flush;
        w_count_nxt = count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Issue registers, tag counter and saturating issue counter; tag and
    // issue count survive a flush and clear only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en     <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_tag    <= '0;
            r_tag_ctr  <= '0;
            issued_cnt <= '0;
        end else if (w_pop) begin
            alu_en    <= 1'b1;
            alu_op    <= OP_W'(w_head.op);
            alu_a     <= DATA_W'(w_head.a);
            alu_b     <= DATA_W'(w_head.b);
            alu_tag   <= r_tag_ctr;
            r_tag_ctr <= r_tag_ctr + TAG_W'(1);
            if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
        end else begin
            alu_en <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
// ============================================================================
// Module   : tb_alu_cmd_issue
// Brief    : Self-checking bench for alu_cmd_issue with a command scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_issue;
    import alu_pkg::*;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              flush     = 1'b0;
    logic              alu_stall = 1'b0;
    logic [OP_W-1:0]   in_op     = '0;
    logic [DATA_W-1:0] in_a      = '0;
    logic [DATA_W-1:0] in_b      = '0;
    logic              in_ready;
    logic              alu_en;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [TAG_W-1:0]  alu_tag;
    logic [CNT_W-1:0]  count;
    logic [15:0]       issued_cnt;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] m_tag = '0;
    int               n_checks = 0;
    int               n_fail   = 0;

    alu_cmd_issue #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .alu_stall  (alu_stall),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_tag    (alu_tag),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for one edge and record what the ALU should later see
    task automatic push1(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        exp_t e;
        check("in_ready_before_push", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        e.op = op;
        e.a  = a;
        e.b  = b;
        sb.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        alu_stall = 1'b0;
        sb.delete();
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
        check("rst_alu_tag", 32'(alu_tag), 32'd0);
        check("rst_alu_op_a_b", {8'd0, 4'd0, alu_op, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Issue monitor: every strobe must match the oldest outstanding command
    // and carry the next sequential tag
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            m_tag = '0;
        end else if (alu_en) begin
            check("issue_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("alu_op", 32'(alu_op), 32'(e.op));
                check("alu_a", 32'(alu_a), 32'(e.a));
                check("alu_b", 32'(alu_b), 32'(e.b));
            end
            check("alu_tag", 32'(alu_tag), 32'(m_tag));
            m_tag = m_tag + TAG_W'(1);
        end
    end

    initial begin
        // Single command: latency and field routing
        do_reset();
        push1(4'h1, 8'h05, 8'h03);
        in_valid = 1'b0;
        check("t1_en_after_push", 32'(alu_en), 32'd0);
        check("t1_count_after_push", 32'(count), 32'd1);
        tick();
        check("t1_en_issue", 32'(alu_en), 32'd1);
        check("t1_op", 32'(alu_op), 32'h1);
        check("t1_a", 32'(alu_a), 32'h05);
        check("t1_b", 32'(alu_b), 32'h03);
        check("t1_tag", 32'(alu_tag), 32'd0);
        check("t1_count_drained", 32'(count), 32'd0);
        tick();
        check("t1_en_one_cycle", 32'(alu_en), 32'd0);
        check("t1_issued_cnt", 32'(issued_cnt), 32'd1);

        // Fill under stall, then drain in order
        do_reset();
        alu_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) push1(4'(i + 2), 8'(8'h10 + i), 8'(8'hF0 - i));
        in_valid = 1'b0;
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd8);
        check("t2_stall_no_en", 32'(alu_en), 32'd0);
        tick();
        check("t2_stall_hold_en", 32'(alu_en), 32'd0);
        alu_stall = 1'b0;
        tick();
        check("t2_resume_no_en", 32'(alu_en), 32'd0);
        tick();
        check("t2_first_en", 32'(alu_en), 32'd1);
        check("t2_first_count", 32'(count), 32'd7);
        check("t2_ready_after_pop", 32'(in_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            check("t2_burst_en", 32'(alu_en), 32'd1);
        end
        tick();
        check("t2_burst_end_en", 32'(alu_en), 32'd0);
        check("t2_drained_count", 32'(count), 32'd0);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Full-rate streaming with tag wrap
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push1(4'(i), 8'(i * 3), 8'(~i));
            check("t3_steady_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("t3_last_en", 32'(alu_en), 32'd1);
        check("t3_last_tag", 32'(alu_tag), 32'd3);
        check("t3_count_zero", 32'(count), 32'd0);
        tick();
        check("t3_issued_cnt", 32'(issued_cnt), 32'd20);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Flush of buffered commands
        do_reset();
        alu_stall = 1'b1;
        for (int i = 0; i < 5; i++) push1(4'h9, 8'(8'hA0 + i), 8'(8'h50 + i));
        in_valid = 1'b0;
        check("t4_buffered_count", 32'(count), 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        check("t4_flush_count", 32'(count), 32'd0);
        check("t4_flush_in_ready", 32'(in_ready), 32'd0);
        check("t4_flush_en", 32'(alu_en), 32'd0);
        tick();
        check("t4_post_flush_ready", 32'(in_ready), 32'd1);
        alu_stall = 1'b0;
        tick();
        check("t4_no_ghost_en", 32'(alu_en), 32'd0);
        push1(4'hA, 8'h11, 8'h22);
        in_valid = 1'b0;
        tick();
        check("t4_new_en", 32'(alu_en), 32'd1);
        check("t4_new_tag", 32'(alu_tag), 32'd0);
        check("t4_issued_cnt", 32'(issued_cnt), 32'd1);

        // Asynchronous reset mid-burst
        do_reset();
        alu_stall = 1'b1;
        for (int i = 0; i < 6; i++) push1(4'h3, 8'(8'h30 + i), 8'(8'h60 + i));
        in_valid  = 1'b0;
        alu_stall = 1'b0;
        tick();
        tick();
        tick();
        check("t5_burst_en", 32'(alu_en), 32'd1);
        check("t5_burst_count", 32'(count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_en", 32'(alu_en), 32'd0);
        check("t5_async_count", 32'(count), 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push1(4'h7, 8'h77, 8'h88);
        in_valid = 1'b0;
        tick();
        check("t5_restart_en", 32'(alu_en), 32'd1);
        check("t5_restart_tag", 32'(alu_tag), 32'd0);
        check("t5_restart_issued", 32'(issued_cnt), 32'd1);
        tick();
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
